// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with a valid/ready handshake and Z/N/C/V status flags.
//   Parameters: WIDTH (operand/result width, >= 4), SHW (low bits of b_in used as the shift amount).
//   Inputs : clk, reset_n (async active-low), in_valid, op[2:0], a_in, b_in, out_ready.
//   Outputs: in_ready, out_valid, result, flags {Z,N,C,V}, illegal.
//   Ops    : 000 ADD, 001 SUB, 010 AND, 011 NOTB, 100 OR, 101 XOR, 110 SHL, 111 MUL.
//   Macro  : ALU_PIPE_MUL_EN adds the iterative shift-add multiplier; without it op 111 is illegal.
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             illegal
);
    localparam int MSB = WIDTH - 1;
    logic             accept;
    logic [WIDTH:0]   add_w, sub_w, shl_w;
    logic [WIDTH-1:0] r_c;
    logic             c_c, v_c, ill_c;
    logic [3:0]       f_c;
    logic             is_mul, busy;
    assign add_w = {1'b0, a_in} + {1'b0, b_in};
    assign sub_w = {1'b0, a_in} + {1'b0, ~b_in} + (WIDTH + 1)'(1);
    // The extra top bit catches the last bit shifted out; it stays 0 for a zero shift.
    assign shl_w = {1'b0, a_in} << b_in[SHW-1:0];
    always_comb begin
        r_c   = '0;
        c_c   = 1'b0;
        v_c   = 1'b0;
        ill_c = 1'b0;
        case (op)
            3'b000: begin
                r_c = add_w[MSB:0];
                c_c = add_w[WIDTH];
                v_c = (a_in[MSB] == b_in[MSB]) && (add_w[MSB] != a_in[MSB]);
            end
            3'b001: begin
                r_c = sub_w[MSB:0];
                c_c = sub_w[WIDTH];
                v_c = (a_in[MSB] != b_in[MSB]) && (sub_w[MSB] != a_in[MSB]);
            end
            3'b010: r_c = a_in & b_in;
            3'b011: r_c = ~b_in;
            3'b100: r_c = a_in | b_in;
            3'b101: r_c = a_in ^ b_in;
            3'b110: begin
                r_c = shl_w[MSB:0];
                c_c = shl_w[WIDTH];
            end
            default: ill_c = 1'b1;
        endcase
    end
    assign f_c = ill_c ? 4'b0000 : {r_c == '0, r_c[MSB], c_c, v_c};
`ifdef ALU_PIPE_MUL_EN
    typedef enum logic {S_IDLE, S_MUL} state_t;
    localparam int CW = $clog2(WIDTH + 1);
    state_t             state;
    logic [2*WIDTH-1:0] mcand, acc, acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    assign is_mul   = op == 3'b111;
    assign busy     = state == S_MUL;
    assign acc_next = acc + (mplier[0] ? mcand : '0);
`else
    assign is_mul = 1'b0;
    assign busy   = 1'b0;
`endif
    // Accepting is safe whenever the output register is empty or drains on this same edge.
    assign in_ready = reset_n && !busy && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
            illegal   <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
            state     <= S_IDLE;
            mcand     <= '0;
            acc       <= '0;
            mplier    <= '0;
            cnt       <= '0;
`endif
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (accept && !is_mul) begin
                result    <= r_c;
                flags     <= f_c;
                illegal   <= ill_c;
                out_valid <= 1'b1;
            end
`ifdef ALU_PIPE_MUL_EN
            if (accept && is_mul) begin
                state  <= S_MUL;
                mcand  <= {{WIDTH{1'b0}}, a_in};
                mplier <= b_in;
                acc    <= '0;
                cnt    <= '0;
            end
            if (busy) begin
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    result    <= acc_next[MSB:0];
                    flags     <= {acc_next[MSB:0] == '0, acc_next[MSB], |acc_next[2*WIDTH-1:WIDTH], 1'b0};
                    illegal   <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= S_IDLE;
                end
            end
`endif
        end
    end
endmodule
